// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds one operand bit pair per cycle, LSB first,
// to an external 1-bit full adder and assembles the WIDTH-bit sum and carry-out.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   s_sh_q;
    logic [WIDTH-1:0]   s_sh_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    // Incoming sum bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
    assign s_sh_d = {fa_sum, s_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign fa_a   = busy & a_sh_q[0];
    assign fa_b   = busy & b_sh_q[0];
    assign fa_cin = busy & carry_q;
    assign sum    = sum_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: a behavioural full adder closes the loop,
// expected {cout,sum} = a+b+cin are queued at start and checked when done is consumed.
module tb_serial_add_seq;

    localparam int unsigned W = 8;
    typedef logic [W:0] res_t;

    logic         clk = 1'b0;
    logic         rst_n, ena, start, cin;
    logic [W-1:0] a, b;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    // Full adder cell modelled arithmetically.
    assign {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    always #5 clk = ~clk;

    res_t exp_q[$];
    int   rise_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pops = 0;
    int   done_hi = 0;
    bit   done_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: a done cycle with ena high is the one the DUT leaves DONE on.
    initial forever begin
        @(negedge clk);
        if (!busy) check("fa_idle_zero", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        if (done) begin
            done_hi++;
            if (!done_prev) rise_q.push_back(cyc);
            if (ena && rst_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result", 32'({cout, sum}), 32'(e));
                end
                pops++;
            end
        end
        done_prev = done;
    end

    task automatic add(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c, input bit rnd);
        int p0;
        bit ok;
        p0 = pops;
        ok = 1'b0;
        exp_q.push_back(res_t'(aa) + res_t'(bb) + res_t'(c));
        start = 1'b1; a = aa; b = bb; cin = c; ena = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            if (rnd) begin
                ena   = ($urandom_range(3) != 0);
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end else begin
                ena   = 1'b1;
                start = 1'b0;
            end
            tick();
            if (pops != p0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("add_timeout", 32'd0, 32'd1);
        start = 1'b0;
        ena   = 1'b1;
    endtask

    initial begin
        int ks, d0, p0, bcnt;
        logic [W-1:0] seq;

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'({busy, done, cout, sum, fa_a, fa_b, fa_cin}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic addition with timing and bit-order checks.
        rise_q.delete();
        d0 = done_hi;
        ks = cyc;
        exp_q.push_back(res_t'(9'h096));
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        tick();
        start = 1'b0;
        bcnt = 0;
        seq = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (i < 8) seq[i] = fa_a;
        end
        tick();
        check("busy_cycles", 32'(bcnt), 32'd8);
        check("fa_a_sequence", 32'(seq), 32'h5A);
        check("done_width", 32'(done_hi - d0), 32'd1);
        check("done_count", 32'(rise_q.size()), 32'd1);
        if (rise_q.size() > 0) check("done_latency", 32'(rise_q[0] - ks), 32'd9);

        add(8'hFF, 8'h01, 1'b0, 1'b0);
        add(8'hFF, 8'hFF, 1'b1, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0);

        // Start held high: back-to-back additions, operands scrambled between accepts.
        rise_q.delete();
        p0 = pops;
        for (int n = 0; n < 3; n++) exp_q.push_back(res_t'(9'h030));
        for (int j = 0; j < 35; j++) begin
            start = (j <= 20);
            if (j % 10 == 0) begin
                a = 8'h10; b = 8'h20; cin = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        check("held_start_count", 32'(pops - p0), 32'd3);
        check("held_start_rises", 32'(rise_q.size()), 32'd3);
        if (rise_q.size() == 3) begin
            check("held_spacing_1", 32'(rise_q[1] - rise_q[0]), 32'd10);
            check("held_spacing_2", 32'(rise_q[2] - rise_q[1]), 32'd10);
        end

        // Asynchronous reset in the 4th RUN cycle discards the addition.
        exp_q.push_back(res_t'(9'h000));
        start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, done, cout, sum, fa_a, fa_b, fa_cin}), 32'd0);
        exp_q.delete();
        d0 = done_hi;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("no_done_after_reset", 32'(done_hi - d0), 32'd0);
        add(8'h77, 8'h66, 1'b1, 1'b0);

        // Stall 3 cycles in RUN and 2 in DONE.
        rise_q.delete();
        d0 = done_hi;
        p0 = pops;
        ks = cyc;
        exp_q.push_back(res_t'(9'h0C3));
        start = 1'b1; a = 8'hA5; b = 8'h1D; cin = 1'b1; ena = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            ena = !((e >= 4 && e <= 6) || e == 12 || e == 13);
            tick();
        end
        ena = 1'b1;
        tick();
        check("stall_done_width", 32'(done_hi - d0), 32'd3);
        check("stall_result_count", 32'(pops - p0), 32'd1);
        if (rise_q.size() > 0) check("stall_latency", 32'(rise_q[0] - ks), 32'd12);
        else check("stall_latency", 32'd0, 32'd12);

        // Random additions with random ena gaps and ignored start/operand noise.
        for (int n = 0; n < 1000; n++) begin
            add(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        for (int i = 0; i < 5; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
